// File: rtl/puzzle_loader_pkg.sv
// Shared constants, FSM encoding and ROM image
// for the puzzle loader.
package puzzle_loader_pkg;

    localparam int CELLS       = 81;
    localparam int NUM_PUZZLES = 8;
    localparam int ADDR_W      = 10;
    localparam int BOARD_W     = 4 * CELLS;
    localparam int IMG_W       = 4 * NUM_PUZZLES * CELLS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Cell k lives in board bits [4k+3:4k].
    function automatic logic [8:0] cell_lsb(input logic [6:0] k);
        return {k, 2'b00};
    endfunction

    // Puzzles in reading order: first hex digit is cell 0.
    localparam logic [BOARD_W-1:0] PUZ0 = 324'h530070000_600195000_098000060_800060003_400803001_700020006_060000280_000419005_000080079;
    localparam logic [BOARD_W-1:0] PUZ1 = 324'hf10000000_000000000_000000000_000000000_000000000_000000000_000000000_000000000_00000009f;
    localparam logic [BOARD_W-1:0] PUZ3 = 324'h534678912_672195348_198342567_859761423_4268c3791_713924856_961537284_287419635_345286179;
    localparam logic [BOARD_W-1:0] PUZ5 = 324'h534678912_672195348_198342567_859761423_426853791_713924856_961537284_287419635_345286179;

    function automatic logic [BOARD_W-1:0] puzzle_image(input int i);
        case (i)
            0:       return PUZ0;
            1:       return PUZ1;
            3:       return PUZ3;
            5:       return PUZ5;
            default: return '0;
        endcase
    endfunction

    // Flat ROM image: word (p*CELLS + k) holds cell k of puzzle p.
    function automatic logic [IMG_W-1:0] rom_image();
        logic [IMG_W-1:0]   img;
        logic [BOARD_W-1:0] p;
        img = '0;
        for (int i = 0; i < NUM_PUZZLES; i++) begin
            p = puzzle_image(i);
            for (int k = 0; k < CELLS; k++) begin
                img[(i*CELLS + k)*4 +: 4] = p[(CELLS-1-k)*4 +: 4];
            end
        end
        return img;
    endfunction

endpackage

// File: rtl/puzzle_loader_rom.sv
// Puzzle ROM: 4-bit words, one-cycle registered read,
// address = sel*81 + cell.
module puzzle_rom
    import puzzle_loader_pkg::*;
#(
    parameter int NUM_PUZZLES = puzzle_loader_pkg::NUM_PUZZLES,
    parameter int CELLS       = puzzle_loader_pkg::CELLS
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [3:0]        data
);

    localparam int IMG_DEPTH = IMG_W / 4;
    localparam int REQ_DEPTH = NUM_PUZZLES * CELLS;
    localparam int DEPTH     = (REQ_DEPTH < IMG_DEPTH) ? REQ_DEPTH : IMG_DEPTH;

    localparam logic [IMG_W-1:0] IMG = rom_image();

    // Registered read; addresses past the image read as blank.
    always_ff @(posedge clk) begin
        if (int'(addr) < DEPTH) begin
            data <= IMG[{addr, 2'b00} +: 4];
        end else begin
            data <= 4'd0;
        end
    end

endmodule

// File: rtl/puzzle_loader.sv
// Copies one ROM puzzle into the board registers,
// then pulses start for the solver.
module puzzle_loader
    import puzzle_loader_pkg::*;
#(
    parameter int NUM_PUZZLES = puzzle_loader_pkg::NUM_PUZZLES,
    parameter int CELLS       = puzzle_loader_pkg::CELLS
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [2:0]     puzzle_sel,
    output logic           busy,
    output logic           start,
    output logic [323:0]   init_board,
    output logic [80:0]    init_board_blank,
    output logic [6:0]     clue_count,
    output logic           bad_cell
);

    state_t            state;
    state_t            state_n;
    logic [2:0]        sel_q;
    logic [6:0]        rd_cnt;
    logic [6:0]        wr_cnt;
    logic              rd_v;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;

    assign rom_addr = ADDR_W'(sel_q) * ADDR_W'(CELLS)
                    + ADDR_W'(rd_cnt);

    puzzle_rom #(
        .NUM_PUZZLES (NUM_PUZZLES),
        .CELLS       (CELLS)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and status outputs.
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        start   = 1'b0;
        case (state)
            S_IDLE: begin
                if (load) state_n = S_FETCH;
            end
            S_FETCH: begin
                busy = 1'b1;
                if (rd_v && wr_cnt == 7'(CELLS-1)) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                start   = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Read pointer, write pointer and board registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q            <= '0;
            rd_cnt           <= '0;
            wr_cnt           <= '0;
            rd_v             <= 1'b0;
            init_board       <= '0;
            init_board_blank <= '0;
            clue_count       <= '0;
            bad_cell         <= 1'b0;
        end else begin
            rd_v <= 1'b0;
            if (state == S_IDLE && load) begin
                sel_q            <= puzzle_sel;
                rd_cnt           <= '0;
                wr_cnt           <= '0;
                init_board       <= '0;
                init_board_blank <= '0;
                clue_count       <= '0;
                bad_cell         <= 1'b0;
            end
            if (state == S_FETCH) begin
                if (rd_cnt < 7'(CELLS)) begin
                    rd_cnt <= rd_cnt + 7'd1;
                    rd_v   <= 1'b1;
                end
                if (rd_v && wr_cnt < 7'(CELLS)) begin
                    wr_cnt <= wr_cnt + 7'd1;
                    if (rom_data != 4'd0 && rom_data <= 4'd9) begin
                        init_board[cell_lsb(wr_cnt) +: 4] <= rom_data;
                        init_board_blank[wr_cnt] <= 1'b0;
                        clue_count <= clue_count + 7'd1;
                    end else begin
                        init_board[cell_lsb(wr_cnt) +: 4] <= 4'd0;
                        init_board_blank[wr_cnt] <= 1'b1;
                        if (rom_data > 4'd9) bad_cell <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
